// File: rtl/dmem_pkg.sv
// dmem_pkg: shared width/state encodings and default data-memory base address
package dmem_pkg;
   typedef enum logic [1:0] {W_BYTE = 2'b00, W_HALF = 2'b01, W_WORD = 2'b10, W_ILL = 2'b11} width_e;
   typedef enum logic [1:0] {S_IDLE = 2'b00, S_WAIT = 2'b01, S_RESP = 2'b10} state_e;
   localparam logic [31:0] DMEM_BASE = 32'h10010000;
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte strobes, store lane replication and load shift/extend
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [1:0]  width_i,
   input  logic [1:0]  lane_i,
   input  logic        unsigned_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rword_i,
   output logic [3:0]  strb_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o
);
   logic [31:0] sh;
   assign sh = rword_i >> {lane_i, 3'b000};
   assign strb_o = (width_i == W_BYTE) ? 4'b0001 << lane_i :
                   (width_i == W_HALF) ? 4'b0011 << lane_i :
                   (width_i == W_WORD) ? 4'b1111 : 4'b0000;
   assign wdata_o = (width_i == W_BYTE) ? {4{wdata_i[7:0]}} :
                    (width_i == W_HALF) ? {2{wdata_i[15:0]}} : wdata_i;
   assign rdata_o = (width_i == W_BYTE) ? {{24{~unsigned_i & sh[7]}}, sh[7:0]} :
                    (width_i == W_HALF) ? {{16{~unsigned_i & sh[15]}}, sh[15:0]} : sh;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: word RAM behind a valid/ready load/store port with fixed wait latency
module dmem_responder
   import dmem_pkg::*;
#(
   parameter logic [31:0] BASE    = DMEM_BASE,
   parameter int          DEPTH   = 1024,
   parameter int          LATENCY = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [31:0] req_addr_i,
   input  logic [1:0]  req_width_i,
   input  logic        req_unsigned_i,
   input  logic [31:0] req_wdata_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [31:0] SPAN = 32'(4 * DEPTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            we_q, we_d, uns_q, uns_d, err_q, err_d;
   logic [1:0]      width_q, width_d, lane_q, lane_d;
   logic [AW-1:0]   idx_q, idx_d;
   logic [31:0]     wdata_q, wdata_d;
   logic            rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
   logic [31:0]     rsp_rdata_q, rsp_rdata_d;
   logic [31:0]     mem [DEPTH];
   logic [31:0]     off, mem_wdata, ld_data;
   logic [3:0]      strb;
   logic            accept, commit, req_err;

   // unsigned subtract makes addresses below BASE wrap to huge offsets and fail the range check
   assign off = req_addr_i - BASE;
   assign req_err = (off >= SPAN) | (req_width_i == W_ILL) |
                    ((req_width_i == W_HALF) & req_addr_i[0]) |
                    ((req_width_i == W_WORD) & (|req_addr_i[1:0]));
   assign req_ready_o = rst_ni & (state_q == S_IDLE);
   assign accept = req_valid_i & req_ready_o;
   assign commit = (state_q == S_WAIT) & (cnt_q == CNT_LAST);
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_err_o = rsp_err_q;

   dmem_lane_align u_align (
      .width_i   (width_q),
      .lane_i    (lane_q),
      .unsigned_i(uns_q),
      .wdata_i   (wdata_q),
      .rword_i   (mem[idx_q]),
      .strb_o    (strb),
      .wdata_o   (mem_wdata),
      .rdata_o   (ld_data)
   );

   // next state: capture on accept, count in WAIT, read/write on leaving WAIT, retire on handshake
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      we_d = we_q;
      uns_d = uns_q;
      err_d = err_q;
      width_d = width_q;
      lane_d = lane_q;
      idx_d = idx_q;
      wdata_d = wdata_q;
      rsp_valid_d = rsp_valid_q;
      rsp_err_d = rsp_err_q;
      rsp_rdata_d = rsp_rdata_q;
      if (accept) begin
         state_d = S_WAIT;
         cnt_d = '0;
         we_d = req_we_i;
         uns_d = req_unsigned_i;
         err_d = req_err;
         width_d = req_width_i;
         lane_d = req_addr_i[1:0];
         idx_d = off[AW+1:2];
         wdata_d = req_wdata_i;
      end
      if (state_q == S_WAIT) cnt_d = cnt_q + 1'b1;
      if (commit) begin
         state_d = S_RESP;
         cnt_d = '0;
         rsp_valid_d = 1'b1;
         rsp_err_d = err_q;
         rsp_rdata_d = (err_q | we_q) ? 32'h0 : ld_data;
      end
      if ((state_q == S_RESP) & rsp_valid_q & rsp_ready_i) begin
         state_d = S_IDLE;
         rsp_valid_d = 1'b0;
      end
   end

   // control, capture and response registers; reset drops any in-flight transaction
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         cnt_q <= '0;
         we_q <= 1'b0;
         uns_q <= 1'b0;
         err_q <= 1'b0;
         width_q <= '0;
         lane_q <= '0;
         idx_q <= '0;
         wdata_q <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         we_q <= we_d;
         uns_q <= uns_d;
         err_q <= err_d;
         width_q <= width_d;
         lane_q <= lane_d;
         idx_q <= idx_d;
         wdata_q <= wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   // RAM byte-lane write, once per store on the WAIT->RESP edge; contents survive reset
   always_ff @(posedge clk_i) begin
      if (commit & we_q & ~err_q)
         for (int b = 0; b < 4; b++)
            if (strb[b]) mem[idx_q][8*b +: 8] <= mem_wdata[8*b +: 8];
   end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and random load/store checks against a byte-level memory model
module tb_dmem_responder;
   localparam logic [31:0] BASE = 32'h10010000;
   localparam int DEPTH = 1024;
   localparam int LAT = 2;

   logic        clk, rst_n, req_valid, req_ready, req_we, req_unsigned;
   logic [31:0] req_addr, req_wdata, rsp_rdata;
   logic [1:0]  req_width;
   logic        rsp_valid, rsp_ready, rsp_err;
   int          checks, errors;
   logic [7:0]  mb [int unsigned];

   dmem_responder #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .req_valid_i   (req_valid),
      .req_ready_o   (req_ready),
      .req_we_i      (req_we),
      .req_addr_i    (req_addr),
      .req_width_i   (req_width),
      .req_unsigned_i(req_unsigned),
      .req_wdata_i   (req_wdata),
      .rsp_valid_o   (rsp_valid),
      .rsp_ready_i   (rsp_ready),
      .rsp_rdata_o   (rsp_rdata),
      .rsp_err_o     (rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic m_err(input logic [31:0] a, input logic [1:0] w);
      logic [31:0] o;
      o = a - BASE;
      return (o >= 32'(4 * DEPTH)) || (w == 2'd3) || (w == 2'd1 && a[0]) || (w == 2'd2 && a[1:0] != 2'd0);
   endfunction

   function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] w, input logic u);
      logic [31:0] o, v;
      int n;
      o = a - BASE;
      n = 1 << w;
      v = 32'h0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = mb[o + 32'(i)];
      if (!u && n == 1) v = {{24{v[7]}}, v[7:0]};
      if (!u && n == 2) v = {{16{v[15]}}, v[15:0]};
      return v;
   endfunction

   task automatic m_store(input logic [31:0] a, input logic [1:0] w, input logic [31:0] d);
      logic [31:0] o;
      o = a - BASE;
      for (int i = 0; i < (1 << w); i++) mb[o + 32'(i)] = d[8*i +: 8];
   endtask

   task automatic xact(input logic we, input logic [31:0] a, input logic [1:0] w, input logic u,
                       input logic [31:0] d, output logic [31:0] rd, output logic e);
      int k;
      @(negedge clk);
      chk("req_ready_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = we; req_addr = a; req_width = w; req_unsigned = u; req_wdata = d;
      @(posedge clk); #1;
      req_valid = 1'b0;
      k = 0;
      do begin
         @(posedge clk); #1;
         k++;
      end while (!rsp_valid && k < 20);
      chk("latency", 32'(k), 32'(LAT));
      rd = rsp_rdata;
      e = rsp_err;
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("valid_retired", 32'(rsp_valid), 32'd0);
   endtask

   task automatic rnd_op();
      logic we, u, e, ee;
      logic [1:0] w;
      logic [31:0] a, d, rd, exp;
      int r;
      r = $urandom_range(0, 9);
      a = (r == 0) ? BASE - 32'($urandom_range(1, 64)) :
          (r == 1) ? BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 64)) :
                     BASE + 32'($urandom_range(0, 63));
      w = 2'($urandom_range(0, 3));
      we = 1'($urandom_range(0, 1));
      u = 1'($urandom_range(0, 1));
      d = $urandom;
      ee = m_err(a, w);
      exp = (ee || we) ? 32'h0 : m_load(a, w, u);
      xact(we, a, w, u, d, rd, e);
      if (we && !ee) m_store(a, w, d);
      chk("rnd_err", 32'(e), 32'(ee));
      chk("rnd_rdata", rd, exp);
   endtask

   initial begin
      logic [31:0] rd;
      logic e;
      int k;
      checks = 0; errors = 0;
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_width = '0;
      req_unsigned = 1'b0; req_wdata = '0; rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rdata", rsp_rdata, 32'h0);
      chk("rst_err", 32'(rsp_err), 32'd0);
      rst_n = 1'b1;
      #1 chk("ready_after_rst", 32'(req_ready), 32'd1);

      for (int i = 0; i < 16; i++) begin
         xact(1'b1, BASE + 32'(4 * i), 2'd2, 1'b0, 32'hA5A50000 | 32'(i), rd, e);
         m_store(BASE + 32'(4 * i), 2'd2, 32'hA5A50000 | 32'(i));
         chk("init_err", 32'(e), 32'd0);
      end

      xact(1'b1, 32'h10010004, 2'd2, 1'b0, 32'hDEADBEEF, rd, e);
      m_store(32'h10010004, 2'd2, 32'hDEADBEEF);
      chk("sw_err", 32'(e), 32'd0);
      chk("sw_rdata", rd, 32'h0);
      xact(1'b0, 32'h10010004, 2'd2, 1'b0, 32'h0, rd, e);
      chk("lw_rdata", rd, 32'hDEADBEEF);
      chk("lw_err", 32'(e), 32'd0);

      xact(1'b0, 32'h10010007, 2'd0, 1'b0, 32'h0, rd, e);
      chk("lb", rd, 32'hFFFFFFDE);
      xact(1'b0, 32'h10010007, 2'd0, 1'b1, 32'h0, rd, e);
      chk("lbu", rd, 32'h000000DE);
      xact(1'b0, 32'h10010006, 2'd1, 1'b0, 32'h0, rd, e);
      chk("lh", rd, 32'hFFFFDEAD);
      xact(1'b0, 32'h10010004, 2'd1, 1'b1, 32'h0, rd, e);
      chk("lhu", rd, 32'h0000BEEF);

      xact(1'b1, 32'h10010005, 2'd0, 1'b0, 32'h00000012, rd, e);
      m_store(32'h10010005, 2'd0, 32'h00000012);
      xact(1'b0, 32'h10010004, 2'd2, 1'b0, 32'h0, rd, e);
      chk("sb_merge", rd, 32'hDEAD12EF);

      xact(1'b0, 32'h10010002, 2'd2, 1'b0, 32'h0, rd, e);
      chk("mis_lw_err", 32'(e), 32'd1);
      chk("mis_lw_rdata", rd, 32'h0);
      xact(1'b1, 32'h10010001, 2'd1, 1'b0, 32'hFFFFFFFF, rd, e);
      chk("mis_sh_err", 32'(e), 32'd1);
      chk("mis_sh_rdata", rd, 32'h0);
      xact(1'b0, 32'h0FFFFFFC, 2'd2, 1'b0, 32'h0, rd, e);
      chk("below_err", 32'(e), 32'd1);
      chk("below_rdata", rd, 32'h0);
      xact(1'b0, BASE + 32'(4 * DEPTH), 2'd2, 1'b0, 32'h0, rd, e);
      chk("above_err", 32'(e), 32'd1);
      chk("above_rdata", rd, 32'h0);
      xact(1'b1, BASE + 32'd8, 2'd3, 1'b0, 32'h0BADF00D, rd, e);
      chk("ill_err", 32'(e), 32'd1);
      chk("ill_rdata", rd, 32'h0);
      xact(1'b0, BASE, 2'd2, 1'b0, 32'h0, rd, e);
      chk("readback0", rd, 32'hA5A50000);
      xact(1'b0, BASE + 32'd8, 2'd2, 1'b0, 32'h0, rd, e);
      chk("readback8", rd, 32'hA5A50002);
      xact(1'b0, 32'h10010004, 2'd2, 1'b0, 32'h0, rd, e);
      chk("readback4", rd, 32'hDEAD12EF);

      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10010004; req_width = 2'd2; req_unsigned = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      k = 0;
      do begin
         @(posedge clk); #1;
         k++;
      end while (!rsp_valid && k < 20);
      chk("hold_latency", 32'(k), 32'(LAT));
      req_valid = 1'b1; req_we = 1'b1; req_addr = BASE; req_wdata = 32'hFFFFFFFF;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("hold_valid", 32'(rsp_valid), 32'd1);
         chk("hold_rdata", rsp_rdata, 32'hDEAD12EF);
         chk("hold_ready", 32'(req_ready), 32'd0);
      end
      @(negedge clk);
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("hold_retired", 32'(rsp_valid), 32'd0);
      repeat (4) @(posedge clk);
      #1 chk("hold_no_accept", 32'(rsp_valid), 32'd0);
      xact(1'b0, BASE, 2'd2, 1'b0, 32'h0, rd, e);
      chk("hold_no_store", rd, 32'hA5A50000);

      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = BASE; req_width = 2'd2; req_wdata = 32'h00000055;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", 32'(rsp_valid), 32'd0);
      chk("midrst_ready", 32'(req_ready), 32'd0);
      chk("midrst_rdata", rsp_rdata, 32'h0);
      chk("midrst_err", 32'(rsp_err), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1 chk("midrst_release", 32'(req_ready), 32'd1);
      xact(1'b0, BASE, 2'd2, 1'b0, 32'h0, rd, e);
      chk("midrst_old", rd, m_load(BASE, 2'd2, 1'b0));

      for (int i = 0; i < 60; i++) rnd_op();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
